// File: rtl/pulse_gate_pkg.sv
// Shared types and default sizing for the pulse-counter measurement sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pulse_gate_pkg;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_GATE_W     = 24;
    localparam int DEF_SETTLE_CYC = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4
    } state_t;

endpackage

// File: rtl/pulse_gate_ctrl_timer.sv
// Loadable down-counter shared by the gate and settle phases.
// Latency: load takes effect on the next edge; o_zero decodes the held count.
// Backpressure: none; counts only while i_run is high and holds at zero.
module gate_timer #(
    parameter int W = 24
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_run,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority; otherwise decrement while running, saturating at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_gate_ctrl.sv
// Measurement sequencer: clear counter, gate for G cycles, settle, latch count.
// Latency: result strobe G+SETTLE_CYC+2 cycles after the start-sampling edge.
// Backpressure: none; start ignored while busy, abort returns to idle next edge.
module pulse_gate_ctrl
    import pulse_gate_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GATE_W     = DEF_GATE_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_cont,
    input  logic [GATE_W-1:0] i_gate_len,
    input  logic [CNT_W-1:0]  i_pulse_cnt,
    output logic              o_cnt_en,
    output logic              o_cnt_clr,
    output logic [CNT_W-1:0]  o_result,
    output logic              o_result_vld,
    output logic              o_ovf,
    output logic              o_busy
);

    // Timer is loaded with length-1 so that o_zero marks the last cycle of a phase.
    localparam logic [GATE_W-1:0] ONE       = {{(GATE_W-1){1'b0}}, 1'b1};
    localparam logic [GATE_W-1:0] SETTLE_LD = GATE_W'(SETTLE_CYC - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_start;
    logic               r_wrap;
    logic               r_cnt_en;
    logic               r_cnt_clr;
    logic               r_result_vld;
    logic               r_ovf;
    logic               r_busy;
    logic [CNT_W-1:0]   r_result;

    logic               w_zero;
    logic               w_load;
    logic               w_run;
    logic [GATE_W-1:0]  w_load_val;
    logic               w_monitor;
    logic               w_wrap_now;

    // Phase timer: gate length in CLEAR, settle length on the last gate cycle.
    gate_timer #(
        .W (GATE_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_run      (w_run),
        .o_zero     (w_zero)
    );

    // Timer control and wrap detection derived from the current state.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = SETTLE_LD;
        w_run      = 1'b0;
        w_monitor  = (r_state == ST_GATE) || (r_state == ST_SETTLE);
        w_wrap_now = w_monitor && (i_pulse_cnt == {CNT_W{1'b1}});
        if (r_state == ST_CLEAR) begin
            w_load     = 1'b1;
            // A zero length still opens the gate for one cycle.
            w_load_val = (i_gate_len == '0) ? '0 : (i_gate_len - ONE);
        end else if ((r_state == ST_GATE) && w_zero) begin
            w_load     = 1'b1;
            w_load_val = SETTLE_LD;
        end else begin
            w_run = w_monitor;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (r_start) w_next = ST_CLEAR;
            ST_CLEAR:  w_next = ST_GATE;
            ST_GATE:   if (w_zero) w_next = ST_SETTLE;
            ST_SETTLE: if (w_zero) w_next = ST_LATCH;
            ST_LATCH:  w_next = i_cont ? ST_CLEAR : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (i_abort) begin
            w_next = ST_IDLE;
        end
    end

    // State register plus start capture; start is only taken while staying idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= i_start && !i_abort && (w_next == ST_IDLE);
        end
    end

    // Sticky wrap flag, cleared at the start of each measurement.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrap <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_wrap <= 1'b0;
        end else if (w_wrap_now) begin
            r_wrap <= 1'b1;
        end
    end

    // Registered outputs decoded from the next state so they align with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt_en     <= 1'b0;
            r_cnt_clr    <= 1'b0;
            r_busy       <= 1'b0;
            r_result_vld <= 1'b0;
            r_result     <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_cnt_en     <= (w_next == ST_GATE);
            r_cnt_clr    <= (w_next == ST_CLEAR);
            r_busy       <= (w_next != ST_IDLE);
            r_result_vld <= (w_next == ST_LATCH);
            if (w_next == ST_LATCH) begin
                r_result <= i_pulse_cnt;
                r_ovf    <= r_wrap || w_wrap_now;
            end
        end
    end

    assign o_cnt_en     = r_cnt_en;
    assign o_cnt_clr    = r_cnt_clr;
    assign o_busy       = r_busy;
    assign o_result_vld = r_result_vld;
    assign o_result     = r_result;
    assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_pulse_gate_ctrl.sv
// Self-checking bench for pulse_gate_ctrl with a behavioural pulse counter attached.
// Latency: expected strobe cycle is tracked per measurement in the scoreboard.
// Backpressure: n/a.
module tb_pulse_gate_ctrl;

    localparam int CNT_W  = 16;
    localparam int GATE_W = 24;
    localparam int S      = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_abort = 1'b0;
    logic              i_cont = 1'b0;
    logic [GATE_W-1:0] gate_len = '0;
    logic              i_pulse = 1'b0;
    logic [CNT_W-1:0]  cnt_model = '0;

    logic              o_cnt_en;
    logic              o_cnt_clr;
    logic [CNT_W-1:0]  o_result;
    logic              o_result_vld;
    logic              o_ovf;
    logic              o_busy;

    typedef struct {
        logic [CNT_W-1:0] res;
        logic             ovf;
        int               at;
    } exp_t;

    exp_t sb[$];
    int   clr_at[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   vld_seen = 0;
    int   en_cycles = 0;
    bit   pulse_on = 1'b0;
    int   pulse_lo = 5;
    int   pulse_hi = 5;
    bit   preset_wrap = 1'b0;

    pulse_gate_ctrl #(
        .CNT_W      (CNT_W),
        .GATE_W     (GATE_W),
        .SETTLE_CYC (S)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_cont       (i_cont),
        .i_gate_len   (gate_len),
        .i_pulse_cnt  (cnt_model),
        .o_cnt_en     (o_cnt_en),
        .o_cnt_clr    (o_cnt_clr),
        .o_result     (o_result),
        .o_result_vld (o_result_vld),
        .o_ovf        (o_ovf),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Enable-gated pulse counter: two-stage synchroniser, rising-edge count.
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    always @(posedge clk) begin
        s1 <= i_pulse;
        s2 <= s1;
        s3 <= s2;
        if (o_cnt_clr)
            cnt_model <= preset_wrap ? 16'hFFFE : 16'h0000;
        else if (o_cnt_en && s2 && !s3)
            cnt_model <= cnt_model + 16'd1;
    end

    // Free-running pulse source: pulse_lo cycles low, pulse_hi cycles high.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pulse_on) begin
                i_pulse = (ph >= pulse_lo);
                ph = (ph + 1) % (pulse_lo + pulse_hi);
            end else begin
                i_pulse = 1'b0;
                ph = 0;
            end
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (o_cnt_en) en_cycles++;
            if (o_cnt_clr) clr_at.push_back(cyc);
            if (o_result_vld) begin
                vld_seen++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_vld: strobe at cycle %0d with no measurement pending", cyc);
                end else begin
                    e = sb.pop_front();
                    if (o_result !== e.res) begin
                        n_errors++;
                        $display("FAIL result: got %0d expected %0d", o_result, e.res);
                    end
                    n_checks++;
                    if (o_ovf !== e.ovf) begin
                        n_errors++;
                        $display("FAIL ovf: got %0b expected %0b", o_ovf, e.ovf);
                    end
                    n_checks++;
                    if (cyc !== e.at) begin
                        n_errors++;
                        $display("FAIL vld_cycle: got %0d expected %0d", cyc, e.at);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise start for one sampling edge; c0 is the cycle count at that edge.
    task automatic launch(input int g, output int c0);
        gate_len = GATE_W'(g);
        i_start  = 1'b1;
        @(posedge clk);
        #1;
        c0      = cyc;
        i_start = 1'b0;
    endtask

    task automatic push_exp(input int res, input bit ovf, input int at);
        exp_t e;
        e.res = CNT_W'(res);
        e.ovf = ovf;
        e.at  = at;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while ((o_busy || sb.size() != 0) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, pending %0d expected 0", tag, k, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++;
        if ({o_cnt_en, o_cnt_clr, o_result_vld, o_busy, o_ovf} !== 5'b0 || o_result !== '0) begin
            n_errors++;
            $display("FAIL reset_hold: flags %b result %0d expected 0", {o_cnt_en, o_cnt_clr, o_result_vld, o_busy, o_ovf}, o_result);
        end
        rst_n = 1'b1;
        tick(2);
        n_checks++;
        if ({o_cnt_en, o_cnt_clr, o_result_vld, o_busy, o_ovf} !== 5'b0 || o_result !== '0) begin
            n_errors++;
            $display("FAIL reset_idle: flags %b result %0d expected 0", {o_cnt_en, o_cnt_clr, o_result_vld, o_busy, o_ovf}, o_result);
        end
    endtask

    task automatic test_gate_short();
        int c0;
        for (int g = 0; g < 2; g++) begin
            en_cycles = 0;
            launch(g, c0);
            push_exp(0, 1'b0, c0 + 7);
            wait_done(50, "gate_short");
            n_checks++;
            if (en_cycles !== 1) begin
                n_errors++;
                $display("FAIL gate_len%0d_en_cycles: got %0d expected 1", g, en_cycles);
            end
        end
    endtask

    task automatic test_single_shot();
        int c0;
        pulse_lo = 50;
        pulse_hi = 30;
        pulse_on = 1'b1;
        en_cycles = 0;
        launch(4000, c0);
        push_exp(50, 1'b0, c0 + 4006);
        tick(3);
        gate_len = GATE_W'(5);
        wait_done(5000, "single");
        n_checks++;
        if (en_cycles !== 4000) begin
            n_errors++;
            $display("FAIL single_en_cycles: got %0d expected 4000", en_cycles);
        end
        tick(5);
        n_checks++;
        if (o_result !== 16'd50) begin
            n_errors++;
            $display("FAIL single_result_hold: got %0d expected 50", o_result);
        end
        pulse_on = 1'b0;
    endtask

    task automatic test_continuous();
        int c0;
        pulse_lo = 5;
        pulse_hi = 5;
        pulse_on = 1'b1;
        tick(2);
        clr_at.delete();
        i_cont = 1'b1;
        launch(100, c0);
        for (int i = 1; i <= 3; i++) push_exp(10, 1'b0, c0 + 106 * i);
        tick(215);
        i_cont = 1'b0;
        wait_done(400, "cont");
        n_checks++;
        if (clr_at.size() !== 3) begin
            n_errors++;
            $display("FAIL cont_clr_count: got %0d expected 3", clr_at.size());
        end
        for (int i = 1; i < clr_at.size(); i++) begin
            n_checks++;
            if (clr_at[i] - clr_at[i-1] !== 106) begin
                n_errors++;
                $display("FAIL cont_clr_spacing: got %0d expected 106", clr_at[i] - clr_at[i-1]);
            end
        end
    endtask

    task automatic test_abort();
        int c0;
        int v0;
        v0 = vld_seen;
        launch(1000, c0);
        tick(51);
        n_checks++;
        if (o_cnt_en !== 1'b1 || o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_pre: en %b busy %b expected 1 1", o_cnt_en, o_busy);
        end
        i_abort = 1'b1;
        tick(1);
        i_abort = 1'b0;
        n_checks++;
        if (o_cnt_en !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_drop: en %b busy %b expected 0 0", o_cnt_en, o_busy);
        end
        tick(1100);
        n_checks++;
        if (vld_seen !== v0 || o_result !== 16'd10 || o_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_hold: strobes %0d result %0d ovf %b expected 0 10 0", vld_seen - v0, o_result, o_ovf);
        end
        launch(20, c0);
        push_exp(2, 1'b0, c0 + 26);
        wait_done(100, "abort_restart");
    endtask

    task automatic test_wrap();
        int c0;
        preset_wrap = 1'b1;
        launch(30, c0);
        push_exp(1, 1'b1, c0 + 36);
        wait_done(100, "wrap");
        preset_wrap = 1'b0;
        launch(30, c0);
        push_exp(3, 1'b0, c0 + 36);
        wait_done(100, "nowrap");
    endtask

    task automatic test_start_while_busy();
        int c0;
        int v0;
        v0 = vld_seen;
        launch(50, c0);
        push_exp(5, 1'b0, c0 + 56);
        tick(10);
        i_start = 1'b1;
        tick(20);
        i_start = 1'b0;
        wait_done(150, "busy_start");
        tick(80);
        n_checks++;
        if (vld_seen - v0 !== 1) begin
            n_errors++;
            $display("FAIL busy_start_strobes: got %0d expected 1", vld_seen - v0);
        end
    endtask

    task automatic test_reset_mid_gate();
        int c0;
        int v0;
        launch(200, c0);
        tick(20);
        n_checks++;
        if (o_cnt_en !== 1'b1) begin
            n_errors++;
            $display("FAIL midgate_en: got %b expected 1", o_cnt_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_cnt_en, o_cnt_clr, o_result_vld, o_busy, o_ovf} !== 5'b0 || o_result !== '0) begin
            n_errors++;
            $display("FAIL async_reset: flags %b result %0d expected 0", {o_cnt_en, o_cnt_clr, o_result_vld, o_busy, o_ovf}, o_result);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v0 = vld_seen;
        tick(300);
        n_checks++;
        if (vld_seen !== v0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: strobes %0d busy %b expected 0 0", vld_seen - v0, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_gate_short();
        test_single_shot();
        test_continuous();
        test_abort();
        test_wrap();
        test_start_while_busy();
        test_reset_mid_gate();
        n_checks++;
        if (sb.size() !== 0) begin
            n_errors++;
            $display("FAIL leftover_expected: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
